// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI access controller.
package hpi_pkg;

    // Bus cycle phases of one HPI access
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } hpi_state_e;

    // HPI register selects
    localparam logic [1:0] DATA    = 2'd0;
    localparam logic [1:0] MAILBOX = 2'd1;
    localparam logic [1:0] ADDRESS = 2'd2;
    localparam logic [1:0] STATUS  = 2'd3;

    // Requester indices
    localparam logic REQ_NIOS = 1'b0;
    localparam logic REQ_KEY  = 1'b1;

    // One-hot response vector for a recorded owner
    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == REQ_KEY) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // 1 = requester 1 was granted last; reset value gives requester 0 priority
    logic last;

    // Contention goes to the requester not served last; a lone request always wins
    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end

    // Pointer moves only when a grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            last <= 1'b1;
        else if (en && |gnt)   last <= gnt[1];
    end

endmodule

// File: rtl/hpi_access_ctrl.sv
// Sequences NIOS and keycode-poller accesses onto the HPI bus with
// programmable setup/strobe/hold/recovery timing. All outputs registered.
import hpi_pkg::*;

module hpi_access_ctrl #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  otg_hpi_address,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in,
    output logic        busy
);

    localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYCLES - 1);

    hpi_state_e        state, nxt_state;
    logic [3:0]        cnt, cnt_nxt;
    logic              do_grant;
    logic [1:0]        gnt;
    logic              gidx;
    logic              bus_nxt;
    logic              launch;

    logic              we_q;
    logic              owner_q;
    logic [1:0]        addr_q;
    logic [15:0]       wdata_q;

    logic [1:0][1:0]   addr_v;
    logic [1:0][15:0]  wdata_v;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    rr_arb2 u_arb (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .req   (req_valid),
        .en    (do_grant),
        .gnt   (gnt)
    );

    assign gidx = gnt[REQ_KEY];

    // A grant cycle is spent in IDLE with req_ready high; the access launches after it
    assign launch  = (state == IDLE) && (req_ready != 2'b00);
    assign bus_nxt = nxt_state inside {SETUP, STROBE, HOLD};

    // Phase sequencing; arbitration happens in IDLE or in the final RECOVER cycle
    // so back-to-back accesses lose no cycle
    always_comb begin
        nxt_state = state;
        cnt_nxt   = cnt;
        do_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    nxt_state = SETUP;
                    cnt_nxt   = SETUP_LD;
                end else if (|req_valid) begin
                    do_grant  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    nxt_state = STROBE;
                    cnt_nxt   = STROBE_LD;
                end else cnt_nxt = cnt - 4'd1;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    nxt_state = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else cnt_nxt = cnt - 4'd1;
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    nxt_state = RECOVER;
                    cnt_nxt   = RECOVER_LD;
                end else cnt_nxt = cnt - 4'd1;
            end
            RECOVER: begin
                if (cnt == 4'd0) begin
                    nxt_state = IDLE;
                    cnt_nxt   = 4'd0;
                    do_grant  = |req_valid;
                end else cnt_nxt = cnt - 4'd1;
            end
            default: begin
                nxt_state = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and phase counter
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nxt_state;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the granted request so the requester may move on after req_ready
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            we_q    <= 1'b0;
            owner_q <= REQ_NIOS;
            addr_q  <= 2'd0;
            wdata_q <= 16'd0;
        end else if (do_grant) begin
            we_q    <= req_we[gidx];
            owner_q <= gidx;
            addr_q  <= addr_v[gidx];
            wdata_q <= wdata_v[gidx];
        end
    end

    // Pad controls follow the next phase so each pin changes on the phase boundary
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            otg_hpi_cs_n     <= 1'b1;
            otg_hpi_r_n      <= 1'b1;
            otg_hpi_w_n      <= 1'b1;
            otg_hpi_data_oe  <= 1'b0;
            otg_hpi_address  <= 2'd0;
            otg_hpi_data_out <= 16'd0;
        end else begin
            otg_hpi_cs_n    <= !bus_nxt;
            otg_hpi_r_n     <= !((nxt_state == STROBE) && !we_q);
            otg_hpi_w_n     <= !((nxt_state == STROBE) && we_q);
            otg_hpi_data_oe <= bus_nxt && we_q;
            if (launch) begin
                otg_hpi_address <= addr_q;
                if (we_q) otg_hpi_data_out <= wdata_q;
            end
        end
    end

    // Handshake outputs: accept pulse, completion pulse, read capture, busy
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            req_ready <= 2'b00;
            rsp_valid <= 2'b00;
            rsp_rdata <= 16'd0;
            busy      <= 1'b0;
        end else begin
            req_ready <= do_grant ? gnt : 2'b00;
            rsp_valid <= ((state == HOLD) && (nxt_state == RECOVER)) ?
                         owner_onehot(owner_q) : 2'b00;
            if ((state == STROBE) && (nxt_state == HOLD) && !we_q)
                rsp_rdata <= otg_hpi_data_in;
            busy      <= (nxt_state != IDLE);
        end
    end

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Randomized scoreboard bench for hpi_access_ctrl with a phase-offset pin model.
import hpi_pkg::*;

module tb_hpi_access_ctrl;

    localparam int S = 1, T = 4, H = 1, R = 2;
    localparam int PER = 1 + S + T + H + R;
    localparam int RSP_OFF = 1 + S + T + H;

    typedef struct {
        int          due;
        logic [1:0]  own;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0, req_we = '0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_ready, rsp_valid, address;
    logic [15:0] rsp_rdata, data_out;
    logic [15:0] data_in = '0;
    logic        cs_n, r_n, w_n, oe, busy;

    logic [1:0]  sw_req_valid = '0, sw_req_we = '0;
    logic [3:0]  sw_req_addr = '0;
    logic [31:0] sw_req_wdata = '0;
    logic [1:0]  sw_req_ready, sw_rsp_valid, sw_address;
    logic [15:0] sw_rsp_rdata, sw_data_out;
    logic [15:0] sw_data_in = '0;
    logic        sw_cs_n, sw_r_n, sw_w_n, sw_oe, sw_busy;

    int checks = 0, errors = 0;
    int cyc = 0;
    bit mon_en = 0, beef = 0, cont = 0;
    int cont_base = 0, acc_count = 0;

    // reference model state
    exp_t        q[$];
    bit          act = 0;
    int          acc_cyc = 0, last_acc = -1000, rd_cyc = -1;
    logic        last_gnt = 1'b1;
    logic        a_we;
    logic [1:0]  a_addr;
    logic [15:0] a_wdata, rd_val;

    always #5 clk = ~clk;

    hpi_access_ctrl u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .otg_hpi_address(address), .otg_hpi_cs_n(cs_n), .otg_hpi_r_n(r_n), .otg_hpi_w_n(w_n),
        .otg_hpi_data_out(data_out), .otg_hpi_data_oe(oe), .otg_hpi_data_in(data_in),
        .busy(busy)
    );

    hpi_access_ctrl #(.SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3), .RECOVER_CYCLES(1)) u_sw (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req_valid(sw_req_valid), .req_we(sw_req_we), .req_addr(sw_req_addr), .req_wdata(sw_req_wdata),
        .req_ready(sw_req_ready), .rsp_valid(sw_rsp_valid), .rsp_rdata(sw_rsp_rdata),
        .otg_hpi_address(sw_address), .otg_hpi_cs_n(sw_cs_n), .otg_hpi_r_n(sw_r_n), .otg_hpi_w_n(sw_w_n),
        .otg_hpi_data_out(sw_data_out), .otg_hpi_data_oe(sw_oe), .otg_hpi_data_in(sw_data_in),
        .busy(sw_busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // One cycle of requester behaviour: drop on ready, maybe issue a fresh request
    task automatic tick(input int p);
        @(posedge clk);
        #3;
        for (int i = 0; i < 2; i++) begin
            if (req_ready[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(99) < p) begin
                req_valid[i]          = 1'b1;
                req_we[i]             = 1'($urandom_range(1));
                req_addr[2*i +: 2]    = 2'($urandom);
                req_wdata[16*i +: 16] = 16'($urandom);
            end
        end
        data_in = (cyc == rd_cyc) ? rd_val : 16'($urandom);
    endtask

    task automatic settle();
        int n = 0;
        tick(0);
        while (!(req_valid == 2'b00 && !busy && q.size() == 0) && n < 200) begin
            tick(0);
            n++;
        end
        chk("settle_timeout", 32'(n < 200), 32'd1);
    endtask

    // Monitor: pin model by cycle offset from accept, grant model, response scoreboard
    int   m_off;
    logic e_cs, e_st, e_busy;
    logic [1:0] m_eg;
    logic m_own;
    exp_t m_e;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            if (act && (cyc - acc_cyc) >= PER) act = 0;
            m_off  = cyc - acc_cyc;
            e_cs   = act && m_off >= 1 && m_off <= S + T + H;
            e_st   = act && m_off >= S + 1 && m_off <= S + T;
            e_busy = act && m_off >= 1;
            chk("pins", {cs_n, r_n, w_n, oe, busy},
                {!e_cs, !(e_st && !a_we), !(e_st && a_we), e_cs && a_we, e_busy});
            chk("protocol", {!r_n && !w_n, oe && !r_n}, 2'b00);
            if (e_cs) begin
                chk("addr", address, a_addr);
                if (a_we) chk("wdata", data_out, a_wdata);
            end
            while (q.size() != 0 && q[0].due < cyc) begin
                chk("rsp_missing", 32'(q[0].due), 32'(cyc));
                void'(q.pop_front());
            end
            if (rsp_valid != 2'b00) begin
                if (q.size() == 0) chk("rsp_spurious", rsp_valid, 2'b00);
                else begin
                    m_e = q.pop_front();
                    chk("rsp_owner", rsp_valid, m_e.own);
                    chk("rsp_time", 32'(cyc), 32'(m_e.due));
                    if (m_e.rd) chk("rsp_rdata", rsp_rdata, m_e.data);
                end
            end
            if (req_ready != 2'b00) begin
                m_eg = (req_valid == 2'b11) ? (last_gnt ? 2'b01 : 2'b10) : req_valid;
                chk("grant", req_ready, m_eg);
                if (cont && acc_count > cont_base) chk("spacing", 32'(cyc - last_acc), 32'(PER));
                else chk("spacing_min", 32'((cyc - last_acc) >= PER), 32'd1);
                m_own    = req_ready[1];
                last_gnt = m_own;
                last_acc = cyc;
                act      = 1;
                acc_cyc  = cyc;
                a_we     = req_we[m_own];
                a_addr   = req_addr[2*m_own +: 2];
                a_wdata  = req_wdata[16*m_own +: 16];
                rd_val   = beef ? 16'hBEEF : 16'($urandom);
                rd_cyc   = cyc + S + T;
                m_e.due  = cyc + RSP_OFF;
                m_e.own  = req_ready;
                m_e.rd   = !a_we;
                m_e.data = rd_val;
                q.push_back(m_e);
                acc_count++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n, prev, wl, rl, rc;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {cs_n, r_n, w_n, oe, busy, address, req_ready, rsp_valid}, 11'b111_0_0_00_00_00);
        chk("reset_data", {data_out, rsp_rdata}, 32'h0);
        chk("sw_reset_ctrl", {sw_cs_n, sw_r_n, sw_w_n, sw_oe, sw_busy, sw_req_ready, sw_rsp_valid},
            9'b111_0_0_00_00);
        @(posedge clk);
        #4;
        rst_n  = 1'b1;
        mon_en = 1;

        // directed write from the NIOS side
        req_we[REQ_NIOS] = 1'b1;
        req_addr[1:0]    = ADDRESS;
        req_wdata[15:0]  = 16'h1234;
        req_valid[0]     = 1'b1;
        settle();

        // directed read from the keycode poller with a known pad value
        beef = 1;
        req_we[REQ_KEY]  = 1'b0;
        req_addr[3:2]    = DATA;
        req_valid[1]     = 1'b1;
        settle();
        beef = 0;

        // sustained contention: grants must alternate at full rate
        cont_base = acc_count;
        cont = 1;
        for (int c = 0; c < 80 && acc_count < cont_base + 4; c++) tick(100);
        chk("contention_accepts", 32'(acc_count - cont_base >= 4), 32'd1);
        cont = 0;
        settle();

        // random traffic
        base = acc_count;
        for (int c = 0; c < 25000 && acc_count < base + 1000; c++) tick(30);
        chk("random_accepts", 32'(acc_count - base >= 1000), 32'd1);
        settle();

        // reset during the strobe of a write
        req_we[0] = 1'b1;
        req_addr[1:0] = MAILBOX;
        req_wdata[15:0] = 16'hC0DE;
        req_valid[0] = 1'b1;
        base = acc_count;
        for (int c = 0; c < 40 && acc_count == base; c++) tick(0);
        chk("rst_accept", 32'(acc_count - base), 32'd1);
        tick(0); tick(0); tick(0);
        chk("pre_reset_strobe", {cs_n, w_n}, 2'b00);
        #2;
        rst_n  = 1'b0;
        mon_en = 0;
        #1;
        chk("reset_mid", {cs_n, r_n, w_n, oe, busy, rsp_valid}, 7'b111_0_0_00);
        q.delete();
        act = 0;
        last_gnt = 1'b1;
        last_acc = -1000;
        rd_cyc = -1;
        req_valid = 2'b11;
        req_we = 2'b10;
        req_addr = {STATUS, ADDRESS};
        req_wdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        #5;
        rst_n  = 1'b1;
        mon_en = 1;
        base = acc_count;
        settle();
        chk("post_reset_accepts", 32'(acc_count - base), 32'd2);

        // timing sweep on the second instance
        sw_req_valid = 2'b01;
        sw_req_we    = 2'b01;
        sw_req_addr  = {2'b00, ADDRESS};
        sw_req_wdata = 32'h0000_A5A5;
        n = 0; prev = 0; wl = 0; rl = 0; rc = 0;
        for (int c = 0; c < 40; c++) begin
            tick(0);
            if (!sw_w_n) wl++;
            if (!sw_r_n) rl++;
            if (sw_rsp_valid != 2'b00) begin
                rc++;
                chk("sw_rsp_owner", sw_rsp_valid, 2'b01);
            end
            if (!sw_cs_n) chk("sw_bus", {sw_address, sw_data_out, sw_oe, sw_busy}, {ADDRESS, 16'hA5A5, 2'b11});
            if (sw_req_ready != 2'b00) begin
                if (n > 0) begin
                    chk("sw_spacing", 32'(c - prev), 32'd8);
                    chk("sw_strobe_len", 32'(wl), 32'd1);
                end
                wl = 0;
                prev = c;
                n++;
                if (n == 3) sw_req_valid = 2'b00;
            end
        end
        chk("sw_accepts", 32'(n), 32'd3);
        chk("sw_rsp_count", 32'(rc), 32'd3);
        chk("sw_last_strobe", 32'(wl), 32'd1);
        chk("sw_read_strobe", 32'(rl), 32'd0);

        chk("rsp_pending", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpi_access_ctrl.md
Name: hpi_access_ctrl

Overview:
Sequences all accesses to the CY7C67200 USB host port interface (HPI) and generates its chip-select, read-strobe and write-strobe timing. Two requesters share the one HPI bus through a round-robin arbiter:
- port 0: the NIOS-side PIO bridge;
- port 1: the hardware keycode poller.

The block sits between those requesters and the otg_hpi pins. It owns the bus-direction control of the tri-state data pins.

Parameters:
SETUP_CYCLES, 1, cycles with CS and address stable before the strobe (range 1..15)
STROBE_CYCLES, 4, cycles the RD/WR strobe is held low (range 1..15)
HOLD_CYCLES, 1, cycles with CS, address and write data held after the strobe (range 1..15)
RECOVER_CYCLES, 2, cycles with CS high before the next access (range 1..15)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester access request, bit i = requester i
req_we  in  2  per-requester write enable (1 = write, 0 = read)
req_addr  in  4  {addr1[1:0], addr0[1:0]} HPI register select
req_wdata  in  32  {wdata1[15:0], wdata0[15:0]}
req_ready  out  2  one-hot accept pulse; request is consumed on the cycle this is high
rsp_valid  out  2  one-hot completion pulse to the owning requester
rsp_rdata  out  16  read data, valid while rsp_valid is nonzero; reads only
otg_hpi_address  out  2  HPI address
otg_hpi_cs_n  out  1  chip select, active low
otg_hpi_r_n  out  1  read strobe, active low
otg_hpi_w_n  out  1  write strobe, active low
otg_hpi_data_out  out  16  write data to the pad
otg_hpi_data_oe  out  1  pad output enable
otg_hpi_data_in  in  16  data from the pad
busy  out  1  high in any state other than IDLE

Behaviour:
Reset:
- Applies asynchronously.
- Values: cs_n = r_n = w_n = 1, data_oe = 0, address = 0, data_out = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0.
- Arbiter pointer is set so requester 0 has priority; state = IDLE.
- Reset mid-transfer deasserts the strobes immediately and drops the transaction without a response.

All outputs are registered. FSM states are IDLE, SETUP, STROBE, HOLD, RECOVER. One 4-bit down-counter loads PARAM-1 on each state entry and the state advances when it reads 0.

IDLE:
- If any req_valid bit is high, grant one requester:
  - with both high, grant the requester not granted last;
  - with one high, grant it regardless of the pointer.
- Pulse req_ready for the granted requester in that same cycle.
- Latch we, addr and wdata, and record the owner.
- Go to SETUP.

SETUP:
- cs_n = 0 and address is driven.
- For a write, data_oe = 1 and data_out = wdata.

STROBE:
- Read: r_n = 0. Write: w_n = 0.
- On a read, otg_hpi_data_in is captured at the clock edge that ends the last STROBE cycle.

HOLD:
- Strobe returns high.
- cs_n, address, data_oe and data_out are held unchanged.

RECOVER:
- cs_n = 1, data_oe = 0.
- In the first RECOVER cycle, pulse rsp_valid for the owner. On a read, rsp_rdata holds the captured data; on a write it is don't-care.
- After the last RECOVER cycle, return to IDLE.

Timing and protocol rules:
- Accept to next possible accept: 1 + SETUP + STROBE + HOLD + RECOVER cycles (9 with the defaults).
- r_n and w_n are never low together.
- data_oe is never high during a read.
- req_valid changes while busy are ignored.
- A requester holds req_valid until it sees its req_ready bit.
- The arbiter pointer updates only on a grant.

Decomposition:
- Package hpi_pkg:
  - state enum hpi_state_e;
  - localparams for the HPI register addresses: DATA = 0, MAILBOX = 1, ADDRESS = 2, STATUS = 3;
  - requester index constants REQ_NIOS = 0, REQ_KEY = 1.
- Sub-module rr_arb2: a 2-way round-robin arbiter with its last-grant pointer. It is purely sequential in the pointer and combinational in the grant.

Test Plan:
- Single write, defaults: requester 0 writes 0x1234 to addr 2, request accepted at cycle 0.
  - cs_n low cycles 1–6; w_n low cycles 2–5; data_oe high cycles 1–6 with data_out = 0x1234.
  - rsp_valid = 2'b01 at cycle 7; req_ready can pulse again at cycle 9.
- Single read: requester 1 reads addr 0 while the bench drives data_in = 0xBEEF during cycle 5.
  - r_n low cycles 2–5; data_oe stays 0.
  - rsp_valid = 2'b10 with rsp_rdata = 0xBEEF at cycle 7.
- Contention: both requesters hold req_valid for 4 consecutive transactions.
  - Grants alternate 0, 1, 0, 1, each spaced 9 cycles apart.
  - Each rsp_valid is routed to its own owner.
- Parameter sweep with SETUP = 2, STROBE = 1, HOLD = 3, RECOVER = 1.
  - Strobe is low for exactly 1 cycle; accept-to-accept spacing is 8 cycles.
- Reset mid-transfer: reset_reset_n asserted low during STROBE of a write.
  - Within the same cycle, w_n = 1, cs_n = 1, data_oe = 0, and no rsp_valid.
  - After release, requester 0 is granted first.
- Protocol assertions over 1000 random requests:
  - r_n and w_n never both low;
  - data_oe is never 1 while r_n = 0;
  - exactly one rsp_valid per req_ready.
